tm_source_scheduler: RTL

Per-simulation-step scheduler for the wind-turbine mechanical torque input `tm`. On each step it selects the torque source: a fixed preset during the start-up window, the live `tm_temp` from the turbine torque pipeline afterwards, or an optional step disturbance. It handshakes with the upstream pipeline, enforces a timeout, and issues one qualified torque word per step to the generator mechanical model.

---
 rtl/tm_source_scheduler.sv | 120 ++++++++++++
 1 files changed

// File: rtl/tm_source_scheduler.sv
// Per-step torque source scheduler: preset, live tm_temp with timeout, or step disturbance (TM_STEP_DIST_EN).
// Issue one cycle after step_start (preset) or after tm_temp_vld (live); late step_start is dropped and flagged in overrun.
module tm_source_scheduler #(
    parameter int unsigned              WIDTH_TIME = 32,
    parameter int unsigned              SINGLE     = 32,
    parameter logic [WIDTH_TIME-1:0]    T_RELEASE  = 10000,
    parameter logic [SINGLE-1:0]        TM_PRESET  = 32'hC1F00000,
    parameter int unsigned              TIMEOUT    = 64,
    parameter logic [WIDTH_TIME-1:0]    T_STEP_ON  = 20000,
    parameter logic [WIDTH_TIME-1:0]    T_STEP_OFF = 30000,
    parameter logic [SINGLE-1:0]        TM_STEP    = 32'hC2200000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  step_start,
    input  logic [WIDTH_TIME-1:0] sim_time,
    input  logic [SINGLE-1:0]     tm_temp,
    input  logic                  tm_temp_vld,
    output logic [SINGLE-1:0]     tm,
    output logic                  tm_vld,
    output logic                  tm_stale,
    output logic [1:0]            phase,
    output logic                  overrun
);

    typedef enum logic [1:0] {IDLE, WAIT_LIVE, ISSUE} state_t;
    typedef enum logic [1:0] {SRC_PRESET, SRC_LIVE, SRC_STALE} src_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

`ifdef TM_STEP_DIST_EN
    localparam bit DIST_EN = 1'b1;
`else
    localparam bit DIST_EN = 1'b0;
`endif

    state_t                state;
    src_t                  src;
    logic [7:0]            cnt;
    logic [WIDTH_TIME-1:0] t_lat;
    logic [SINGLE-1:0]     tm_hold;
    logic                  in_window;

    // Disturbance only ever applies after the preset window has closed.
    assign in_window = DIST_EN && (t_lat > T_RELEASE) &&
                       (t_lat >= T_STEP_ON) && (t_lat < T_STEP_OFF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            src      <= SRC_PRESET;
            cnt      <= 8'd0;
            t_lat    <= '0;
            tm_hold  <= TM_PRESET;
            tm       <= TM_PRESET;
            tm_vld   <= 1'b0;
            tm_stale <= 1'b0;
            phase    <= 2'd0;
            overrun  <= 1'b0;
        end else begin
            tm_vld <= 1'b0;
            case (state)
                IDLE: begin
                    if (step_start) begin
                        t_lat <= sim_time;
                        if (sim_time <= T_RELEASE) begin
                            src   <= SRC_PRESET;
                            state <= ISSUE;
                        end else begin
                            cnt   <= 8'd0;
                            state <= WAIT_LIVE;
                        end
                    end
                end
                WAIT_LIVE: begin
                    if (step_start) overrun <= 1'b1;
                    cnt <= cnt + 8'd1;
                    // A valid on the final timeout cycle still counts as live.
                    if (tm_temp_vld) begin
                        tm_hold <= tm_temp;
                        src     <= SRC_LIVE;
                        state   <= ISSUE;
                    end else if (cnt == CNT_LAST) begin
                        src   <= SRC_STALE;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (step_start) overrun <= 1'b1;
                    tm_vld <= 1'b1;
                    state  <= IDLE;
                    case (src)
                        SRC_PRESET: begin
                            tm       <= TM_PRESET;
                            phase    <= 2'd0;
                            tm_stale <= 1'b0;
                        end
                        SRC_LIVE: begin
                            tm_stale <= 1'b0;
                            if (in_window) begin
                                tm    <= TM_STEP;
                                phase <= 2'd2;
                            end else begin
                                tm    <= tm_hold;
                                phase <= 2'd1;
                            end
                        end
                        default: begin
                            tm       <= tm_hold;
                            phase    <= 2'd1;
                            tm_stale <= 1'b1;
                        end
                    endcase
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
